// File: rtl/riscv_defines.sv
// Shared pipeline types for the hazard interface: memory-access and
// control-flow encodings, the request/response bundles, pipeline tags and
// the requester FSM state.
package riscv_defines;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_access_t;

  typedef enum logic [1:0] {
    CF_SEQ    = 2'd0,
    CF_BRANCH = 2'd1,
    CF_JUMP   = 2'd2,
    CF_TRAP   = 2'd3
  } cflow_mode_t;

  // Packed MSB-first: raw_data_id is bit 4, branch_mispredict is bit 0.
  typedef struct packed {
    logic raw_data_id;
    logic raw_data_ex;
    logic load_use;
    logic store_data;
    logic branch_mispredict;
  } hazard_cause_t;

  localparam int NUM_CAUSES = 5;

  typedef struct packed {
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic        regwrite_e;
    mem_access_t memaccess_e;
    logic [4:0]  rd_m;
    logic        regwrite_m;
    mem_access_t memaccess_m;
    logic [4:0]  rs2_m;
    logic [4:0]  rd_w;
    logic        regwrite_w;
    cflow_mode_t cflow_mode;
    logic        mispredict;
    logic        flushflag;
  } hazard_req_t;

  typedef struct packed {
    logic          stall_f;
    logic          stall_d;
    logic          flush_d;
    logic          flush_e;
    logic          flush_m;
    hazard_cause_t hazard_cause;
  } hazard_res_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwrite;
    mem_access_t memaccess;
  } hazard_tag_t;

  localparam hazard_tag_t HAZARD_TAG_BUBBLE = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, regwrite: 1'b0, memaccess: MEM_NONE
  };

  // Statistics fields are a fixed width; narrower counters are zero-extended.
  localparam int HAZARD_STATS_W = 32;

  typedef struct packed {
    logic [HAZARD_STATS_W-1:0] raw_data_id;
    logic [HAZARD_STATS_W-1:0] raw_data_ex;
    logic [HAZARD_STATS_W-1:0] load_use;
    logic [HAZARD_STATS_W-1:0] store_data;
    logic [HAZARD_STATS_W-1:0] branch_mispredict;
  } hazard_stats_t;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } requester_state_t;

endpackage

// File: rtl/hazard_interface.sv
// Point-to-point link between the pipeline requester and the hazard unit.
interface hazard_interface;
  import riscv_defines::*;

  hazard_req_t req;
  hazard_res_t res;

  modport requester (output req, input res);
  modport unit      (input req, output res);
endinterface

// File: rtl/hazard_requester_tag_stage.sv
// One pipeline tag register (E, M or W): sync reset and flush both load a bubble.
module hazard_tag_stage
  import riscv_defines::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        flush,
  input  hazard_tag_t d,
  output hazard_tag_t q
);

  hazard_tag_t tag_reg;

  // Bubble on reset/flush, otherwise advance the upstream tag.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      tag_reg <= HAZARD_TAG_BUBBLE;
    end else begin
      tag_reg <= d;
    end
  end

  assign q = tag_reg;

endmodule

// File: rtl/hazard_requester.sv
// Requester end of the hazard interface. Shadows the rd/rs/regwrite/memaccess
// tags of in-flight instructions through E/M/W, publishes them on req every
// cycle, and sequences the hazard-unit enable after reset.
// Optional build macro HAZARD_STATS_EN adds per-cause saturating counters
// (CNT_W bits each, CNT_W <= 32) on the stats port.
module hazard_requester
  import riscv_defines::*;
#(
  parameter int STARTUP_CYCLES = 4
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1_d,
  input  logic [4:0]           rs2_d,
  input  logic [4:0]           rd_d,
  input  logic                 regwrite_d,
  input  mem_access_t          memaccess_d,
  input  cflow_mode_t          cflow_mode,
  input  logic                 mispredict,
  input  logic                 flushflag,
  hazard_interface.requester   hazard_bus,
  output logic                 start
`ifdef HAZARD_STATS_EN
  ,
  output hazard_stats_t        stats
`endif
);

  localparam int WARM_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(STARTUP_CYCLES - 1);

  requester_state_t  state_reg, state_next;
  logic [WARM_W-1:0] warm_cnt_reg, warm_cnt_next;
  logic              start_reg;

  // State, warmup counter and registered start (high exactly while in S_RUN).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_RESET;
      warm_cnt_reg <= '0;
      start_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      warm_cnt_reg <= warm_cnt_next;
      start_reg    <= (state_next == S_RUN);
    end
  end

  // Next state: one cycle in S_RESET, STARTUP_CYCLES in S_WARMUP, then S_RUN.
  always_comb begin
    state_next    = state_reg;
    warm_cnt_next = warm_cnt_reg;
    case (state_reg)
      S_RESET: begin
        state_next    = S_WARMUP;
        warm_cnt_next = '0;
      end
      S_WARMUP: begin
        if (warm_cnt_reg == WARM_LAST) begin
          state_next = S_RUN;
        end else begin
          warm_cnt_next = warm_cnt_reg + 1'b1;
        end
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_RESET;
    endcase
  end

  assign start = start_reg;

  // Tags stay bubbles until the hazard unit is live, because before that res
  // is idle and nothing would ever flush stale contents.
  logic        stage_srst;
  hazard_tag_t tag_d, tag_e, tag_m, tag_w;

  assign stage_srst = reset | ~start_reg;
  assign tag_d = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                   regwrite: regwrite_d, memaccess: memaccess_d};

  // Stall is deliberately ignored: a load-use bubble reaches E via flush_e.
  hazard_tag_stage u_tag_e (
    .clk(clk), .srst(stage_srst), .flush(hazard_bus.res.flush_e), .d(tag_d), .q(tag_e)
  );
  hazard_tag_stage u_tag_m (
    .clk(clk), .srst(stage_srst), .flush(hazard_bus.res.flush_m), .d(tag_e), .q(tag_m)
  );
  hazard_tag_stage u_tag_w (
    .clk(clk), .srst(stage_srst), .flush(1'b0), .d(tag_m), .q(tag_w)
  );

  hazard_req_t req_comb;

  // Request is purely combinational so the hazard unit sees it with no added latency.
  always_comb begin
    req_comb             = '0;
    req_comb.rs1_d       = rs1_d;
    req_comb.rs2_d       = rs2_d;
    req_comb.rs1_e       = tag_e.rs1;
    req_comb.rs2_e       = tag_e.rs2;
    req_comb.rd_e        = tag_e.rd;
    req_comb.regwrite_e  = tag_e.regwrite;
    req_comb.memaccess_e = tag_e.memaccess;
    req_comb.rd_m        = tag_m.rd;
    req_comb.regwrite_m  = tag_m.regwrite;
    req_comb.memaccess_m = tag_m.memaccess;
    req_comb.rs2_m       = tag_m.rs2;
    req_comb.rd_w        = tag_w.rd;
    req_comb.regwrite_w  = tag_w.regwrite;
    req_comb.cflow_mode  = cflow_mode;
    req_comb.mispredict  = mispredict;
    req_comb.flushflag   = flushflag;
  end

  assign hazard_bus.req = req_comb;

`ifdef HAZARD_STATS_EN
  logic [NUM_CAUSES-1:0] cause_vec;
  assign cause_vec = hazard_bus.res.hazard_cause;

  for (genvar gi = 0; gi < NUM_CAUSES; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    // Count run-time cycles with this cause raised, sticking at all-ones.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (start_reg && cause_vec[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stats.raw_data_id       = HAZARD_STATS_W'(g_cnt[4].cnt_reg);
  assign stats.raw_data_ex       = HAZARD_STATS_W'(g_cnt[3].cnt_reg);
  assign stats.load_use          = HAZARD_STATS_W'(g_cnt[2].cnt_reg);
  assign stats.store_data        = HAZARD_STATS_W'(g_cnt[1].cnt_reg);
  assign stats.branch_mispredict = HAZARD_STATS_W'(g_cnt[0].cnt_reg);
`endif

endmodule
